// File: rtl/ntt_ctrl.sv
`default_nettype none
// ============================================================================
// ntt_ctrl : butterfly issue / write-back sequencer for an in-place 256-point
//            forward or inverse NTT (7 layers x 128 butterflies, Kyber order).
// Revision   : 1.0
// ============================================================================
module ntt_ctrl #(
    parameter int unsigned BF_LAT = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       inv_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [6:0] zeta_idx_o,
    output logic       bf_inv_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o
);

    localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT - 1);
    localparam logic [2:0] LAST_LAYER = 3'd6;
    localparam logic [6:0] LAST_BFLY  = 7'd127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [2:0] layer, layer_n;
    logic [6:0] bfly, bfly_n;
    logic [2:0] drain_cnt, drain_cnt_n;
    logic       inv_q, inv_n;
    logic       done_q, done_n;
    logic       issue;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            layer     <= 3'd0;
            bfly      <= 7'd0;
            drain_cnt <= 3'd0;
            inv_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            layer     <= layer_n;
            bfly      <= bfly_n;
            drain_cnt <= drain_cnt_n;
            inv_q     <= inv_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        layer_n     = layer;
        bfly_n      = bfly;
        drain_cnt_n = drain_cnt;
        inv_n       = inv_q;
        done_n      = 1'b0;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n     = ISSUE;
                    layer_n     = 3'd0;
                    bfly_n      = 7'd0;
                    drain_cnt_n = 3'd0;
                    inv_n       = inv_i;
                end
            end
            ISSUE: begin
                issue  = 1'b1;
                bfly_n = bfly + 7'd1;
                if (bfly == LAST_BFLY) begin
                    state_n     = DRAIN;
                    drain_cnt_n = 3'd0;
                end
            end
            DRAIN: begin
                drain_cnt_n = drain_cnt + 3'd1;
                // Leave DRAIN only once the layer's last write-back has landed.
                if (drain_cnt == DRAIN_LAST) begin
                    drain_cnt_n = 3'd0;
                    if (layer < LAST_LAYER) begin
                        layer_n = layer + 3'd1;
                        bfly_n  = 7'd0;
                        state_n = ISSUE;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Butterfly span is 2^shamt: shrinking per layer forward, growing inverse.
    logic [2:0] shamt;
    logic [7:0] bfly8;
    logic [7:0] span;
    logic [7:0] grp;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [6:0] zeta;

    always_comb begin
        shamt  = inv_q ? (layer + 3'd1) : (3'd7 - layer);
        bfly8  = {1'b0, bfly};
        span   = 8'd1 << shamt;
        grp    = bfly8 >> shamt;
        addr_a = (grp << ({1'b0, shamt} + 4'd1)) | (bfly8 & (span - 8'd1));
        addr_b = addr_a + span;
        zeta   = inv_q ? ((7'd127 >> layer) - grp[6:0])
                       : ((7'd1 << layer) + grp[6:0]);
    end

    assign rd_en_o     = issue;
    assign rd_addr_a_o = issue ? addr_a : 8'd0;
    assign rd_addr_b_o = issue ? addr_b : 8'd0;
    assign zeta_idx_o  = issue ? zeta : 7'd0;
    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;
    assign bf_inv_o    = inv_q;

    logic       dl_v [BF_LAT];
    logic [7:0] dl_a [BF_LAT];
    logic [7:0] dl_b [BF_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BF_LAT); i++) begin
                dl_v[i] <= 1'b0;
                dl_a[i] <= 8'd0;
                dl_b[i] <= 8'd0;
            end
        end else begin
            dl_v[0] <= issue;
            dl_a[0] <= rd_addr_a_o;
            dl_b[0] <= rd_addr_b_o;
            for (int i = 1; i < int'(BF_LAT); i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
        end
    end

    assign wr_en_o     = dl_v[BF_LAT-1];
    assign wr_addr_a_o = dl_a[BF_LAT-1];
    assign wr_addr_b_o = dl_b[BF_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_ntt_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ntt_ctrl : scoreboard bench for ntt_ctrl (BF_LAT=3 and BF_LAT=1 instances)
// Revision    : 1.0
// ============================================================================
module tb_ntt_ctrl;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] z;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic inv_in;
    logic sel;

    int checks   = 0;
    int failures = 0;

    ent_t exp_q[$];
    ent_t wq[$];

    always #5 clk = ~clk;

    logic       st3, st1;
    logic       busy3, done3, rd3, inv3, wr3, busy1, done1, rd1, inv1, wr1;
    logic [7:0] ra3, rb3, wa3, wb3, ra1, rb1, wa1, wb1;
    logic [6:0] z3, z1;

    assign st3 = sel ? 1'b0 : start;
    assign st1 = sel ? start : 1'b0;

    ntt_ctrl #(.BF_LAT(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st3), .inv_i(inv_in),
        .busy_o(busy3), .done_o(done3), .rd_en_o(rd3),
        .rd_addr_a_o(ra3), .rd_addr_b_o(rb3), .zeta_idx_o(z3),
        .bf_inv_o(inv3), .wr_en_o(wr3), .wr_addr_a_o(wa3), .wr_addr_b_o(wb3)
    );

    ntt_ctrl #(.BF_LAT(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st1), .inv_i(inv_in),
        .busy_o(busy1), .done_o(done1), .rd_en_o(rd1),
        .rd_addr_a_o(ra1), .rd_addr_b_o(rb1), .zeta_idx_o(z1),
        .bf_inv_o(inv1), .wr_en_o(wr1), .wr_addr_a_o(wa1), .wr_addr_b_o(wb1)
    );

    logic       o_busy, o_done, o_rd, o_inv, o_wr;
    logic [7:0] o_ra, o_rb, o_wa, o_wb;
    logic [6:0] o_z;

    always_comb begin
        o_busy = sel ? busy1 : busy3;
        o_done = sel ? done1 : done3;
        o_rd   = sel ? rd1   : rd3;
        o_inv  = sel ? inv1  : inv3;
        o_wr   = sel ? wr1   : wr3;
        o_ra   = sel ? ra1   : ra3;
        o_rb   = sel ? rb1   : rb3;
        o_wa   = sel ? wa1   : wa3;
        o_wb   = sel ? wb1   : wb3;
        o_z    = sel ? z1    : z3;
    end

    // Reference butterfly order written the way the Kyber reference loops it.
    task automatic build_model(input bit inv);
        int   k;
        ent_t e;
        exp_q.delete();
        wq.delete();
        if (!inv) begin
            k = 1;
            for (int len = 128; len >= 2; len = len / 2)
                for (int st = 0; st < 256; st = st + 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        e.a = 8'(j); e.b = 8'(j + len); e.z = 7'(k);
                        exp_q.push_back(e);
                    end
                    k++;
                end
        end else begin
            k = 127;
            for (int len = 2; len <= 128; len = len * 2)
                for (int st = 0; st < 256; st = st + 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        e.a = 8'(j); e.b = 8'(j + len); e.z = 7'(k);
                        exp_q.push_back(e);
                    end
                    k--;
                end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({o_busy, o_done, o_rd, o_inv, o_wr, o_ra, o_rb, o_wa, o_wb, o_z} !== '0) begin
            failures++;
            $display("FAIL %s outputs got busy=%0b done=%0b rd=%0b inv=%0b wr=%0b ra=%0d rb=%0d wa=%0d wb=%0d z=%0d exp all 0",
                     tag, o_busy, o_done, o_rd, o_inv, o_wr, o_ra, o_rb, o_wa, o_wb, o_z);
        end
    endtask

    // Entered at the negedge of cycle 0; returns at a negedge with the DUT idle
    // (or at the done cycle when chaining, or at cycle abort_at).
    task automatic run_xfer(input bit inv, input bit skip_start, input bit poke,
                            input bit chain, input bit chain_inv, input int abort_at);
        int   lat = sel ? 1 : 3;
        int   P   = 128 + lat;
        int   rd_count = 0;
        int   wr_count = 0;
        bit   er, ew;
        ent_t e, w;
        if (!skip_start) begin
            start  = 1'b1;
            inv_in = inv;
        end
        build_model(inv);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 7 * P + 1; n++) begin
            er = (n <= 7 * P) && (((n - 1) % P) < 128);
            ew = (n - lat >= 1) && (n - lat <= 7 * P) && (((n - lat - 1) % P) < 128);
            checks++;
            if (o_rd !== er) begin
                failures++;
                $display("FAIL rd_en lat=%0d n=%0d got=%0b exp=%0b", lat, n, o_rd, er);
            end
            checks++;
            if (o_wr !== ew) begin
                failures++;
                $display("FAIL wr_en lat=%0d n=%0d got=%0b exp=%0b", lat, n, o_wr, ew);
            end
            checks++;
            if (o_busy !== (n <= 7 * P)) begin
                failures++;
                $display("FAIL busy lat=%0d n=%0d got=%0b exp=%0b", lat, n, o_busy, (n <= 7 * P));
            end
            checks++;
            if (o_done !== (n == 7 * P + 1)) begin
                failures++;
                $display("FAIL done lat=%0d n=%0d got=%0b exp=%0b", lat, n, o_done, (n == 7 * P + 1));
            end
            checks++;
            if (o_inv !== inv) begin
                failures++;
                $display("FAIL bf_inv lat=%0d n=%0d got=%0b exp=%0b", lat, n, o_inv, inv);
            end
            if (er) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                wq.push_back(e);
                checks++;
                if (o_ra !== e.a || o_rb !== e.b || o_z !== e.z) begin
                    failures++;
                    $display("FAIL issue lat=%0d n=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                             lat, n, o_ra, o_rb, o_z, e.a, e.b, e.z);
                end
            end
            if (ew) begin
                w = (wq.size() > 0) ? wq.pop_front() : '0;
                checks++;
                if (o_wa !== w.a || o_wb !== w.b) begin
                    failures++;
                    $display("FAIL writeback lat=%0d n=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             lat, n, o_wa, o_wb, w.a, w.b);
                end
            end
            if (o_rd === 1'b1) rd_count++;
            if (o_wr === 1'b1) wr_count++;
            if (n == abort_at) begin
                start = 1'b0;
                return;
            end
            if (chain && n == 7 * P + 1) begin
                start  = 1'b1;
                inv_in = chain_inv;
                return;
            end
            start = poke && (n == 50 || n == 600);
            if (start) inv_in = ~inv;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (rd_count != 896 || wr_count != 896) begin
            failures++;
            $display("FAIL pulse_count lat=%0d got rd=%0d wr=%0d exp 896/896", lat, rd_count, wr_count);
        end
    endtask

    task automatic check_quiet(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            check_all_zero("idle");
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        check_quiet(4);
    endtask

    task automatic test_forward();
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_inverse();
        run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // bf_inv holds after the transform until the next accepted start
        checks++;
        if (o_inv !== 1'b1) begin
            failures++;
            $display("FAIL bf_inv_hold got=%0b exp=1", o_inv);
        end
    endtask

    task automatic test_ignore_start();
        run_xfer(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_quiet(5);
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_lat1();
        sel = 1'b1;
        check_all_zero("lat1_idle");
        run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        sel = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        inv_in = 1'b0;
        sel    = 1'b0;
        @(negedge clk);
        test_reset();
        test_forward();
        test_inverse();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_lat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
